// File: rtl/trace_pkg.sv
// Shared types and constants for the trace command sequencer.
package trace_pkg;

    localparam int unsigned OP_W_DEF   = 4;
    localparam int unsigned ADDR_W_DEF = 32;

    localparam logic [OP_W_DEF-1:0] PRINT_OP = 4'h9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GAP   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef struct packed {
        logic [OP_W_DEF-1:0]   op;
        logic [ADDR_W_DEF-1:0] addr;
    } cmd_t;

endpackage

// File: rtl/trace_cmd_sequencer_if.sv
// Load, control and cache-command signals of the trace sequencer.
interface trace_cmd_sequencer_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned OP_W   = 4,
    parameter int unsigned GAP_W  = 8,
    parameter int unsigned IT_W   = 11
);
    localparam int unsigned CMD_W = OP_W + ADDR_W;

    logic              load_valid;
    logic [CMD_W-1:0]  load_data;
    logic              load_ready;
    logic              overflow;
    logic              start;
    logic              mode_in;
    logic [GAP_W-1:0]  gap_cfg;
    logic              cmd_valid;
    logic [CMD_W-1:0]  cmd_data;
    logic              cmd_ready;
    logic              mode_out;
    logic [IT_W-1:0]   iteration;
    logic              done;
    logic              clear;

    modport slave (
        input  load_valid, load_data, start, mode_in, gap_cfg, cmd_ready, clear,
        output load_ready, overflow, cmd_valid, cmd_data, mode_out, iteration, done
    );

    modport master (
        output load_valid, load_data, start, mode_in, gap_cfg, cmd_ready, clear,
        input  load_ready, overflow, cmd_valid, cmd_data, mode_out, iteration, done
    );

endinterface

// File: rtl/trace_mem.sv
// Simple dual-port trace buffer: one write port, one registered read port.
module trace_mem #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/trace_cmd_sequencer.sv
// Buffers a trace of cache commands, then replays them with a programmable
// inter-command gap and closes with a PRINT statistics command.
module trace_cmd_sequencer
    import trace_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned OP_W   = 4,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned GAP_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    trace_cmd_sequencer_if.slave    bus
);

    localparam int unsigned CMD_W = OP_W + ADDR_W;
    localparam int unsigned IT_W  = $clog2(DEPTH + 1);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam logic [OP_W-1:0] PRINT_OP_W = OP_W'(PRINT_OP);

    state_e              state, state_n;
    logic [IT_W-1:0]     count, count_n;
    logic [IT_W-1:0]     rd_ptr, rd_ptr_n;
    logic [IT_W-1:0]     iteration_q, iteration_n;
    logic [GAP_W-1:0]    gap_cnt, gap_cnt_n;
    logic [GAP_W-1:0]    gap_lat, gap_lat_n;
    logic [ADDR_W-1:0]   last_addr, last_addr_n;
    logic                fwd_valid, fwd_valid_n;
    logic [CMD_W-1:0]    fwd_data, fwd_data_n;
    logic                mode_q, mode_n;
    logic                overflow_q, overflow_n;
    logic                load_ready_q, load_ready_n;
    logic                cmd_valid_q, cmd_valid_n;
    logic [CMD_W-1:0]    cmd_data_q, cmd_data_n;
    logic                done_q, done_n;

    logic                load_hs;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [AW-1:0]       rd_addr;
    logic [CMD_W-1:0]    rd_data;
    logic [IT_W-1:0]     ptr_inc;

    // The read address follows the next pointer so rd_data always mirrors mem[rd_ptr].
    assign wr_addr = AW'(count);
    assign rd_addr = AW'(rd_ptr_n);
    assign ptr_inc = rd_ptr + IT_W'(1);
    assign load_hs = (state == ST_IDLE) && bus.load_valid && load_ready_q;

    trace_mem #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (bus.load_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_n     = state;
        count_n     = count;
        rd_ptr_n    = rd_ptr;
        iteration_n = iteration_q;
        gap_cnt_n   = gap_cnt;
        gap_lat_n   = gap_lat;
        last_addr_n = last_addr;
        fwd_valid_n = fwd_valid;
        fwd_data_n  = fwd_data;
        mode_n      = mode_q;
        overflow_n  = overflow_q;
        cmd_valid_n = 1'b0;
        cmd_data_n  = cmd_data_q;
        done_n      = 1'b0;
        wr_en       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (load_hs) begin
                    wr_en   = 1'b1;
                    count_n = count + IT_W'(1);
                end else if (bus.load_valid && (count == IT_W'(DEPTH))) begin
                    overflow_n = 1'b1;
                end
                if (bus.start) begin
                    mode_n      = bus.mode_in;
                    gap_lat_n   = bus.gap_cfg;
                    rd_ptr_n    = '0;
                    iteration_n = '0;
                    gap_cnt_n   = '0;
                    // Entry 0 written on this same edge is not yet visible to the read port.
                    fwd_valid_n = load_hs && (count == '0);
                    fwd_data_n  = bus.load_data;
                    if (count_n != '0) begin
                        state_n = ST_GAP;
                    end else begin
                        state_n     = ST_FINAL;
                        last_addr_n = '0;
                        cmd_valid_n = 1'b1;
                        cmd_data_n  = {PRINT_OP_W, ADDR_W'(0)};
                    end
                end
            end
            ST_GAP: begin
                fwd_valid_n = 1'b0;
                if ((gap_lat == '0) || (gap_cnt == (gap_lat - GAP_W'(1)))) begin
                    state_n     = ST_ISSUE;
                    cmd_valid_n = 1'b1;
                    cmd_data_n  = fwd_valid ? fwd_data : rd_data;
                end else begin
                    gap_cnt_n = gap_cnt + GAP_W'(1);
                end
            end
            ST_ISSUE: begin
                cmd_valid_n = 1'b1;
                if (bus.cmd_ready) begin
                    rd_ptr_n    = ptr_inc;
                    iteration_n = iteration_q + IT_W'(1);
                    last_addr_n = cmd_data_q[ADDR_W-1:0];
                    gap_cnt_n   = '0;
                    if (cmd_data_q[CMD_W-1 -: OP_W] == PRINT_OP_W) begin
                        state_n     = ST_DONE;
                        cmd_valid_n = 1'b0;
                        done_n      = 1'b1;
                    end else if (ptr_inc == count) begin
                        state_n    = ST_FINAL;
                        cmd_data_n = {PRINT_OP_W, cmd_data_q[ADDR_W-1:0]};
                    end else begin
                        state_n     = ST_GAP;
                        cmd_valid_n = 1'b0;
                    end
                end
            end
            ST_FINAL: begin
                cmd_valid_n = 1'b1;
                if (bus.cmd_ready) begin
                    iteration_n = iteration_q + IT_W'(1);
                    state_n     = ST_DONE;
                    cmd_valid_n = 1'b0;
                    done_n      = 1'b1;
                end
            end
            ST_DONE: begin
                done_n = 1'b1;
                if (bus.clear) begin
                    state_n     = ST_IDLE;
                    count_n     = '0;
                    rd_ptr_n    = '0;
                    iteration_n = '0;
                    overflow_n  = 1'b0;
                    done_n      = 1'b0;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        load_ready_n = (state_n == ST_IDLE) && (count_n < IT_W'(DEPTH));
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            count        <= '0;
            rd_ptr       <= '0;
            iteration_q  <= '0;
            gap_cnt      <= '0;
            gap_lat      <= '0;
            last_addr    <= '0;
            fwd_valid    <= 1'b0;
            fwd_data     <= '0;
            mode_q       <= 1'b0;
            overflow_q   <= 1'b0;
            load_ready_q <= 1'b1;
            cmd_valid_q  <= 1'b0;
            cmd_data_q   <= '0;
            done_q       <= 1'b0;
        end else begin
            state        <= state_n;
            count        <= count_n;
            rd_ptr       <= rd_ptr_n;
            iteration_q  <= iteration_n;
            gap_cnt      <= gap_cnt_n;
            gap_lat      <= gap_lat_n;
            last_addr    <= last_addr_n;
            fwd_valid    <= fwd_valid_n;
            fwd_data     <= fwd_data_n;
            mode_q       <= mode_n;
            overflow_q   <= overflow_n;
            load_ready_q <= load_ready_n;
            cmd_valid_q  <= cmd_valid_n;
            cmd_data_q   <= cmd_data_n;
            done_q       <= done_n;
        end
    end

    assign bus.load_ready = load_ready_q;
    assign bus.overflow   = overflow_q;
    assign bus.cmd_valid  = cmd_valid_q;
    assign bus.cmd_data   = cmd_data_q;
    assign bus.mode_out   = mode_q;
    assign bus.iteration  = iteration_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_trace_cmd_sequencer.sv
// Scoreboard bench for trace_cmd_sequencer: a queue-based trace model predicts
// every issued command and its idle gap; a monitor pops and compares.
module tb_trace_cmd_sequencer;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned GAP_W  = 8;
    localparam int unsigned IT_W   = $clog2(DEPTH + 1);
    localparam int unsigned CMD_W  = OP_W + ADDR_W;

    typedef struct {
        logic [CMD_W-1:0] d;
        int               idle;
    } exp_t;

    logic clk;
    logic rst;

    trace_cmd_sequencer_if #(.ADDR_W(ADDR_W), .OP_W(OP_W), .GAP_W(GAP_W), .IT_W(IT_W)) bus ();

    trace_cmd_sequencer #(.ADDR_W(ADDR_W), .OP_W(OP_W), .DEPTH(DEPTH), .GAP_W(GAP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int               n_vec = 0;
    int               n_err = 0;
    logic [CMD_W-1:0] mq[$];
    bit               movf = 1'b0;
    exp_t             expq[$];
    int               exp_n = 0;
    int               hs_cnt = 0;
    int               idle_cnt = 0;
    bit               in_cmd = 1'b0;
    logic [CMD_W-1:0] held;
    bit               rand_ready = 1'b0;
    bit               stall_req = 1'b0;
    int               stall_left = 0;
    bit               rdy;
    exp_t             e;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Monitor: pops the expected command whenever a new one is presented.
    always @(negedge clk) begin
        if (rst) begin
            in_cmd = 1'b0; idle_cnt = 0; stall_left = 0; bus.cmd_ready = 1'b0;
        end else if (bus.start) begin
            idle_cnt = 0; hs_cnt = 0; in_cmd = 1'b0;
        end else if (bus.cmd_valid) begin
            if (!in_cmd) begin
                if (expq.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_cmd: got %h expected none", bus.cmd_data);
                end else begin
                    e = expq.pop_front();
                    chk("cmd_data", 64'(bus.cmd_data), 64'(e.d));
                    chk("idle_gap", 64'(idle_cnt), 64'(e.idle));
                end
                chk("iteration", 64'(bus.iteration), 64'(hs_cnt));
                held   = bus.cmd_data;
                in_cmd = 1'b1;
                if (stall_req && hs_cnt == 1) begin
                    stall_left = 5; stall_req = 1'b0;
                end
            end else begin
                chk("cmd_stable", 64'(bus.cmd_data), 64'(held));
                chk("iter_hold", 64'(bus.iteration), 64'(hs_cnt));
            end
            if (stall_left > 0) begin
                rdy = 1'b0; stall_left--;
            end else begin
                rdy = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            bus.cmd_ready = rdy;
            if (rdy) begin
                in_cmd = 1'b0; hs_cnt++; idle_cnt = 0;
            end
        end else begin
            idle_cnt++;
            bus.cmd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Trace model: commands in load order, stop after a PRINT, else append PRINT.
    task automatic build_exp(input int gap);
        logic [ADDR_W-1:0] la;
        bit printed;
        int g;
        la = '0; printed = 1'b0; g = (gap == 0) ? 1 : gap;
        expq.delete(); exp_n = 0;
        foreach (mq[i]) begin
            expq.push_back('{mq[i], g}); exp_n++;
            la = mq[i][ADDR_W-1:0];
            if (mq[i][CMD_W-1 -: OP_W] == 4'h9) begin
                printed = 1'b1; break;
            end
        end
        if (!printed) begin
            expq.push_back('{{4'h9, la}, 0}); exp_n++;
        end
    endtask

    task automatic load(input logic [CMD_W-1:0] d);
        @(posedge clk); #1 bus.load_valid = 1'b1; bus.load_data = d;
        @(negedge clk); chk("load_ready", 64'(bus.load_ready), 64'(mq.size() < DEPTH));
        @(posedge clk);
        if (mq.size() < DEPTH) mq.push_back(d); else movf = 1'b1;
        #1 bus.load_valid = 1'b0;
    endtask

    task automatic run(input int gap, input bit m, input bit with_load, input logic [CMD_W-1:0] ld);
        bit ok;
        @(posedge clk); #1 bus.start = 1'b1; bus.mode_in = m; bus.gap_cfg = GAP_W'(gap);
        if (with_load) begin
            bus.load_valid = 1'b1; bus.load_data = ld;
        end
        @(negedge clk);
        if (with_load) chk("load_ready_st", 64'(bus.load_ready), 64'(mq.size() < DEPTH));
        @(posedge clk);
        if (with_load) begin
            if (mq.size() < DEPTH) mq.push_back(ld); else movf = 1'b1;
        end
        build_exp(gap);
        #1 bus.start = 1'b0; bus.load_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.done) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL done_timeout: got done=0 expected done=1");
        end else begin
            chk("iter_final", 64'(bus.iteration), 64'(exp_n));
            chk("valid_in_done", 64'(bus.cmd_valid), 64'(0));
            chk("exp_left", 64'(expq.size()), 64'(0));
            chk("overflow", 64'(bus.overflow), 64'(movf));
            chk("mode_out", 64'(bus.mode_out), 64'(m));
            chk("ready_in_done", 64'(bus.load_ready), 64'(0));
        end
        @(posedge clk); #1 bus.clear = 1'b1;
        @(posedge clk); #1 bus.clear = 1'b0;
        @(negedge clk);
        chk("clr_done", 64'(bus.done), 64'(0));
        chk("clr_iter", 64'(bus.iteration), 64'(0));
        chk("clr_ovf", 64'(bus.overflow), 64'(0));
        chk("clr_ready", 64'(bus.load_ready), 64'(1));
        mq.delete(); movf = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 64'(bus.cmd_valid), 64'(0));
        chk({tag, "_data"}, 64'(bus.cmd_data), 64'(0));
        chk({tag, "_done"}, 64'(bus.done), 64'(0));
        chk({tag, "_iter"}, 64'(bus.iteration), 64'(0));
        chk({tag, "_ovf"}, 64'(bus.overflow), 64'(0));
        chk({tag, "_mode"}, 64'(bus.mode_out), 64'(0));
        chk({tag, "_ready"}, 64'(bus.load_ready), 64'(1));
    endtask

    initial begin
        bit ok;
        logic [OP_W-1:0] op;
        rst = 1'b1;
        bus.load_valid = 1'b0; bus.load_data = '0; bus.start = 1'b0;
        bus.mode_in = 1'b0; bus.gap_cfg = '0; bus.clear = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_reset_outputs("rst");
        @(negedge clk); rst = 1'b0;

        // Basic three-command trace, gap 2.
        load(36'h0_00000010); load(36'h1_00000020); load(36'h2_00000030);
        run(2, 1'b1, 1'b0, '0);

        // Five loads into a four-entry buffer.
        for (int i = 0; i < 5; i++) load({4'h3, 32'(i * 16 + 1)});
        run(1, 1'b0, 1'b0, '0);

        // Stall the second command for five cycles.
        stall_req = 1'b1;
        load(36'h4_00000100); load(36'h5_00000200); load(36'h6_00000300);
        run(1, 1'b1, 1'b0, '0);
        stall_req = 1'b0;

        // Empty trace.
        run(3, 1'b0, 1'b0, '0);

        // PRINT inside the trace ends it early.
        load(36'h1_000000A0); load(36'h9_000000B0); load(36'h0_000000C0);
        run(0, 1'b1, 1'b0, '0);

        // Load coincident with start on an empty buffer, gap 0.
        run(0, 1'b0, 1'b1, 36'h7_DEADBEEF);

        // Reset during the gap before the second command.
        load(36'h0_00000010); load(36'h1_00000020); load(36'h2_00000030);
        @(posedge clk); #1 bus.start = 1'b1; bus.gap_cfg = 8'd3; bus.mode_in = 1'b1;
        @(posedge clk); build_exp(3); #1 bus.start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (hs_cnt >= 1) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL first_issue_timeout: got 0 handshakes expected 1");
        end
        @(negedge clk); #2 rst = 1'b1;
        #1 chk_reset_outputs("midrst");
        expq.delete(); mq.delete(); movf = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        run(2, 1'b0, 1'b0, '0);

        // Randomised traces with random back-pressure.
        rand_ready = 1'b1;
        for (int r = 0; r < 12; r++) begin
            int nl;
            nl = $urandom_range(0, 6);
            for (int k = 0; k < nl; k++) begin
                op = 4'($urandom_range(0, 15));
                if (op == 4'h9 && $urandom_range(0, 3) != 0) op = 4'h2;
                load({op, 32'($urandom)});
            end
            run($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/trace_cmd_sequencer.md
TRACE_CMD_SEQUENCER -- requirements
Module: trace_cmd_sequencer

Interface
REQ-001 Parameter ADDR_W, default 32: address field width of each trace command.
REQ-002 Parameter OP_W, default 4: opcode field width of each trace command.
REQ-003 Parameter DEPTH, default 1024: number of trace commands buffered.
REQ-004 Parameter GAP_W, default 8: width of the inter-command gap counter.
REQ-005 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-high reset.
REQ-007 Port load_valid, input, 1: a trace command is offered on load_data.
REQ-008 Port load_data, input, OP_W+ADDR_W: offered command; the opcode occupies the upper OP_W bits.
REQ-009 Port load_ready, output, 1: the sequencer accepts the offered command.
REQ-010 Port overflow, output, 1: sticky flag; a load was offered while the buffer was full.
REQ-011 Port start, input, 1: single-cycle pulse that begins issuing the buffered trace.
REQ-012 Port mode_in, input, 1: cache mode, latched on an accepted start.
REQ-013 Port gap_cfg, input, GAP_W: idle cycles before each issued command, latched on start.
REQ-014 Port cmd_valid, output, 1: cmd_data holds a valid command for the cache.
REQ-015 Port cmd_data, output, OP_W+ADDR_W: command presented to the cache.
REQ-016 Port cmd_ready, input, 1: the cache consumes cmd_data this cycle.
REQ-017 Port mode_out, output, 1: latched mode, driven to the cache.
REQ-018 Port iteration, output, $clog2(DEPTH+1): number of commands consumed so far.
REQ-019 Port done, output, 1: the trace and the final statistics command have been consumed.
REQ-020 Port clear, input, 1: in DONE, return to IDLE and empty the buffer.

Function
REQ-021 The FSM SHALL have the states IDLE, GAP, ISSUE, FINAL and DONE.
REQ-022 In IDLE, load_ready SHALL equal (count<DEPTH).
- A handshake writes mem[count] and increments count.
- In all other states, load_ready SHALL be 0.
REQ-023 load_valid while count==DEPTH in IDLE SHALL drop the data and set overflow, which clears only on reset or clear.
REQ-024 start in IDLE SHALL latch mode_in and gap_cfg, reset rd_ptr and iteration to 0, and go:
- to GAP if count>0;
- to FINAL with final address 0 if count==0.
REQ-025 start outside IDLE SHALL be ignored.
REQ-026 A start coincident with a load handshake SHALL accept the load first; the new count is used.
REQ-027 GAP SHALL wait exactly gap_cfg cycles, then enter ISSUE; gap_cfg==0 SHALL enter ISSUE on the next cycle.
REQ-028 ISSUE SHALL assert cmd_valid with cmd_data=mem[rd_ptr], held stable until cmd_ready.
REQ-029 On the cmd_valid&&cmd_ready handshake in ISSUE:
- rd_ptr and iteration SHALL increment, and the issued address SHALL be stored as last_addr;
- next state is GAP if commands remain, otherwise FINAL.
REQ-030 If an issued command's opcode equals PRINT_OP, the handshake SHALL go directly to DONE, skipping the remaining commands and FINAL.
REQ-031 FINAL SHALL present cmd_data={PRINT_OP,last_addr} with cmd_valid=1; on handshake it SHALL increment iteration and enter DONE.
REQ-032 DONE SHALL hold done=1 and cmd_valid=0.
REQ-033 clear in DONE SHALL zero count, rd_ptr, iteration and overflow and enter IDLE; clear in other states SHALL be ignored.
REQ-034 cmd_valid SHALL never be asserted in IDLE, GAP or DONE.
REQ-035 Opcode and address SHALL pass through unmodified; no arithmetic on the address.

Reset
REQ-036 rst SHALL asynchronously force IDLE with these values:
- count=0, rd_ptr=0, iteration=0, last_addr=0;
- overflow=0, mode_out=0, cmd_valid=0, cmd_data=0, done=0, load_ready=1.
REQ-037 rst asserted mid-issue SHALL abandon the trace; buffer contents are undefined and count=0 after reset.
REQ-038 Buffer RAM contents SHALL need no reset.

Structure
REQ-039 Package trace_pkg SHALL hold:
- the opcode width constant;
- PRINT_OP=4'h9;
- the FSM state enum;
- the command struct {op, addr}.
REQ-040 Buffer storage SHALL be a sub-module trace_mem: simple dual-port, one write and one read port, DEPTH x (OP_W+ADDR_W).
REQ-041 trace_mem reads SHALL be registered.
- The sequencer SHALL prefetch so that cmd_data is valid on the first ISSUE cycle.

Verification
REQ-042 Load 3 commands (0_00000010, 1_00000020, 2_00000030), gap_cfg=2, cmd_ready=1 -> 3 issues each after 2 idle cycles, then 9_00000030; iteration=4; done=1.
REQ-043 With DEPTH=4, load 5 commands -> load_ready=0 after the 4th; the 5th is dropped; overflow=1; 4 commands plus the final command are issued.
REQ-044 Hold cmd_ready=0 for 5 cycles during ISSUE -> cmd_data is constant and iteration is unchanged, then advances one step on ready.
REQ-045 Start with count=0 -> a single 9_00000000 command; done=1; iteration=1.
REQ-046 Trace 1_000000A0, 9_000000B0, 0_000000C0 -> two commands issued; no appended final; done=1; iteration=2.
REQ-047 Assert rst during GAP of the 2nd command -> all outputs at reset values the same cycle; count=0; a subsequent start issues only 9_00000000.
